// File: rtl/cell_test_pkg.sv
// cell_test_pkg: shared FSM states, reference truth tables and lookup for cell testers
package cell_test_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_REPORT, ST_FINISH} state_t;
  localparam logic [15:0] EXP_OAI211 = 16'h1FFF;
  localparam logic [15:0] EXP_AOI211 = 16'h0111;
  localparam logic [15:0] EXP_NAND4  = 16'h7FFF;
  function automatic logic exp_bit(input logic [255:0] tbl, input logic [7:0] idx);
    return tbl[idx];
  endfunction
endpackage

// File: rtl/settle_timer.sv
// settle_timer: loadable down-counter; expire is high while enabled at zero
module settle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] init,
  output logic         expire
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= init;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign expire = en && cnt == '0;
endmodule

// File: rtl/cell_truth_checker.sv
// cell_truth_checker: exhaustive sweep of a combinational cell against an expected truth table
module cell_truth_checker
  import cell_test_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int SETTLE = 10,
  parameter logic [2**N_IN-1:0] EXPECT = EXP_OAI211
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [N_IN-1:0]   vec,
  input  logic              cell_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N_IN-1:0]   res_vec,
  output logic              res_bit,
  output logic              res_err,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic [N_IN-1:0]   first_err_vec,
  output logic [2**N_IN-1:0] obs_table
);
  localparam logic [N_IN-1:0] LAST = '1;
  localparam logic [N_IN:0] ERR_MAX = (N_IN+1)'(2**N_IN);
  state_t state, nxt;
  logic expire, accept, go, miss;
  assign go = state == ST_IDLE && start;
  assign accept = state == ST_REPORT && res_ready;
  assign miss = cell_out ^ exp_bit(256'(EXPECT), 8'(vec));
  settle_timer #(.W(8)) u_timer (
    .clk(clk), .rst(rst), .load(go || accept), .en(state == ST_SETTLE),
    .init(8'(SETTLE-1)), .expire(expire)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   nxt = start ? ST_SETTLE : ST_IDLE;
      ST_SETTLE: nxt = expire ? ST_SAMPLE : ST_SETTLE;
      ST_SAMPLE: nxt = ST_REPORT;
      ST_REPORT: nxt = !res_ready ? ST_REPORT : vec == LAST ? ST_FINISH : ST_SETTLE;
      default:   nxt = ST_IDLE;
    endcase
  end
  always_comb begin
    res_valid = state == ST_REPORT;
    busy = state != ST_IDLE;
    done = state == ST_FINISH;
  end
  // vec only advances on accept, so it stays frozen while a result is pending
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vec <= '0;
      res_vec <= '0;
      res_bit <= 1'b0;
      res_err <= 1'b0;
      err_count <= '0;
      first_err_vec <= '0;
      obs_table <= '0;
      pass <= 1'b0;
    end else begin
      if (go) begin
        vec <= '0;
        err_count <= '0;
        first_err_vec <= '0;
        obs_table <= '0;
        pass <= 1'b0;
      end
      if (state == ST_SAMPLE) begin
        res_bit <= cell_out;
        res_vec <= vec;
        res_err <= miss;
        obs_table[vec] <= cell_out;
        if (miss && err_count != ERR_MAX) begin
          err_count <= err_count + 1'b1;
          if (err_count == '0) first_err_vec <= vec;
        end
      end
      if (accept && vec != LAST) vec <= vec + 1'b1;
      if (state == ST_FINISH) pass <= err_count == '0;
    end
endmodule

// File: tb/tb_cell_truth_checker.sv
// tb_cell_truth_checker: directed scenarios for the OAI211 truth-table sweeper
module tb_cell_truth_checker;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, start12 = 1'b0, res_ready = 1'b1;
  logic cell_out, cell_out12;
  logic [3:0] vec, res_vec, first_err_vec, b_vec, b_res_vec, b_first;
  logic res_valid, res_bit, res_err, busy, done, pass;
  logic b_valid, b_bit, b_err_o, b_busy, b_done, b_pass;
  logic [4:0] err_count, b_err;
  logic [15:0] obs_table, b_obs;
  logic [15:0] exp_tbl = 16'h1FFF;
  logic [3:0] dly[12], dly12[12];
  int mode = 0;
  int checks = 0, errors = 0;
  logic [3:0] got_vec[16];
  logic got_bit[16], got_err[16];
  int n_res, unstable;
  logic [3:0] done_vec;

  always #5 clk = ~clk;

  cell_truth_checker #(.N_IN(4), .SETTLE(10), .EXPECT(16'h1FFF)) dut (
    .clk(clk), .rst(rst), .start(start), .vec(vec), .cell_out(cell_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_vec(res_vec), .res_bit(res_bit),
    .res_err(res_err), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_vec(first_err_vec), .obs_table(obs_table)
  );
  cell_truth_checker #(.N_IN(4), .SETTLE(12), .EXPECT(16'h1FFF)) dut12 (
    .clk(clk), .rst(rst), .start(start12), .vec(b_vec), .cell_out(cell_out12),
    .res_valid(b_valid), .res_ready(res_ready), .res_vec(b_res_vec), .res_bit(b_bit),
    .res_err(b_err_o), .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
    .first_err_vec(b_first), .obs_table(b_obs)
  );

  // cell models: ideal, stuck-at-1, and an 11-cycle propagation delay
  always @(posedge clk) begin
    dly[0] <= vec;
    dly12[0] <= b_vec;
    for (int i = 1; i < 12; i++) begin
      dly[i] <= dly[i-1];
      dly12[i] <= dly12[i-1];
    end
  end
  assign cell_out = mode == 0 ? exp_tbl[vec] : mode == 1 ? 1'b1 : exp_tbl[dly[10]];
  assign cell_out12 = exp_tbl[dly12[10]];

  task automatic do_reset();
    rst = 1'b1;
    repeat (15) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic sweep(input bit stall, input int poke_c, output int lat);
    int hold = 0;
    logic [3:0] cv, cd;
    logic cb, ce;
    lat = -1;
    n_res = 0;
    unstable = 0;
    res_ready = !stall;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 1; c < 2000; c++) begin
      start = c == poke_c;
      if (res_valid) begin
        if (hold == 0) begin
          if (n_res < 16) begin
            got_vec[n_res] = res_vec;
            got_bit[n_res] = res_bit;
            got_err[n_res] = res_err;
          end
          n_res++;
          cv = res_vec; cb = res_bit; ce = res_err; cd = vec;
        end else if ({res_vec, res_bit, res_err, vec} !== {cv, cb, ce, cd}) unstable++;
        hold++;
        res_ready = !stall || hold == 6;
      end else begin
        hold = 0;
        res_ready = !stall;
      end
      if (done) begin
        lat = c;
        done_vec = vec;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    res_ready = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({vec, res_valid, busy, done, pass} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl got vec=%0d valid=%b busy=%b done=%b pass=%b exp all 0", vec, res_valid, busy, done, pass);
    end
    checks++;
    if ({err_count, first_err_vec, obs_table} !== 25'h0) begin
      errors++;
      $display("FAIL reset_score got err=%0d first=%0d obs=%h exp 0", err_count, first_err_vec, obs_table);
    end
  endtask

  task automatic test_sweep();
    int lat;
    mode = 0;
    sweep(1'b0, -1, lat);
    checks++;
    if (lat !== 193) begin errors++; $display("FAIL sweep_latency got %0d exp 193", lat); end
    checks++;
    if (n_res !== 16) begin errors++; $display("FAIL sweep_count got %0d exp 16", n_res); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got_vec[i] !== 4'(i) || got_bit[i] !== exp_tbl[i] || got_err[i] !== 1'b0) begin
        errors++;
        $display("FAIL sweep_result[%0d] got vec=%0d bit=%b err=%b exp vec=%0d bit=%b err=0", i, got_vec[i], got_bit[i], got_err[i], i, exp_tbl[i]);
      end
    end
    checks++;
    if (done_vec !== 4'hF) begin errors++; $display("FAIL sweep_lastvec got %0d exp 15", done_vec); end
    @(negedge clk);
    checks++;
    if ({pass, busy, done, err_count} !== {3'b100, 5'd0} || obs_table !== 16'h1FFF) begin
      errors++;
      $display("FAIL sweep_summary got pass=%b busy=%b done=%b err=%0d obs=%h exp 1 0 0 0 1fff", pass, busy, done, err_count, obs_table);
    end
  endtask

  task automatic test_stuck();
    int lat;
    mode = 1;
    sweep(1'b0, -1, lat);
    @(negedge clk);
    checks++;
    if (err_count !== 5'd3 || first_err_vec !== 4'd13) begin
      errors++;
      $display("FAIL stuck_errs got err=%0d first=%0d exp 3 13", err_count, first_err_vec);
    end
    checks++;
    if (pass !== 1'b0 || obs_table !== 16'hFFFF) begin
      errors++;
      $display("FAIL stuck_summary got pass=%b obs=%h exp 0 ffff", pass, obs_table);
    end
    checks++;
    if (got_err[13] !== 1'b1 || got_err[12] !== 1'b0) begin
      errors++;
      $display("FAIL stuck_res_err got e12=%b e13=%b exp 0 1", got_err[12], got_err[13]);
    end
  endtask

  task automatic test_stall();
    int lat;
    mode = 0;
    sweep(1'b1, -1, lat);
    checks++;
    if (lat !== 273) begin errors++; $display("FAIL stall_latency got %0d exp 273", lat); end
    checks++;
    if (unstable !== 0) begin errors++; $display("FAIL stall_stable got %0d changes exp 0", unstable); end
    checks++;
    if (n_res !== 16 || got_vec[9] !== 4'd9 || got_bit[14] !== 1'b0) begin
      errors++;
      $display("FAIL stall_results got n=%0d v9=%0d b14=%b exp 16 9 0", n_res, got_vec[9], got_bit[14]);
    end
  endtask

  task automatic test_delay();
    int c = 0;
    mode = 2;
    do_reset();
    @(negedge clk) begin start = 1'b1; start12 = 1'b1; end
    @(negedge clk) begin start = 1'b0; start12 = 1'b0; end
    while (!b_done && c < 400) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (!b_done) begin errors++; $display("FAIL delay_timeout got no done exp done"); end
    @(negedge clk);
    checks++;
    if (pass !== 1'b0 || err_count !== 5'd1 || first_err_vec !== 4'd13 || obs_table !== 16'h3FFF) begin
      errors++;
      $display("FAIL delay_s10 got pass=%b err=%0d first=%0d obs=%h exp 0 1 13 3fff", pass, err_count, first_err_vec, obs_table);
    end
    checks++;
    if (b_pass !== 1'b1 || b_err !== 5'd0 || b_obs !== 16'h1FFF) begin
      errors++;
      $display("FAIL delay_s12 got pass=%b err=%0d obs=%h exp 1 0 1fff", b_pass, b_err, b_obs);
    end
    mode = 0;
  endtask

  task automatic test_reset_mid();
    int c = 0, nd = 0, lat;
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (vec !== 4'd7 && c < 400) begin
      @(negedge clk);
      c++;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({vec, res_valid, busy, done, pass, err_count, obs_table} !== 29'h0) begin
      errors++;
      $display("FAIL midreset_state got vec=%0d busy=%b err=%0d obs=%h exp 0", vec, busy, err_count, obs_table);
    end
    repeat (5) begin
      @(negedge clk);
      if (done) nd++;
    end
    rst = 1'b0;
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL midreset_done got %0d pulses exp 0", nd); end
    sweep(1'b0, -1, lat);
    @(negedge clk);
    checks++;
    if (lat !== 193 || pass !== 1'b1) begin
      errors++;
      $display("FAIL midreset_resweep got lat=%0d pass=%b exp 193 1", lat, pass);
    end
  endtask

  task automatic test_busy_start();
    int lat, nd = 0;
    mode = 0;
    sweep(1'b0, 55, lat);
    checks++;
    if (lat !== 193) begin errors++; $display("FAIL busystart_latency got %0d exp 193", lat); end
    repeat (30) begin
      @(negedge clk);
      if (done) nd++;
    end
    checks++;
    if (nd !== 0 || busy !== 1'b0 || pass !== 1'b1) begin
      errors++;
      $display("FAIL busystart_single got extra=%0d busy=%b pass=%b exp 0 0 1", nd, busy, pass);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_stuck();
    test_stall();
    test_delay();
    test_reset_mid();
    test_busy_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
